// File: rtl/calculadora_secuencial.sv
// calculadora_secuencial
//   Sequential ALU with a ready/valid request side and a ready/valid result side.
//   Most operations run through a single EXEC cycle. Divide and modulo with a
//   nonzero divisor use a restoring divider that produces one quotient bit per
//   cycle. After each completed result handshake, the delivered result is copied
//   into an accumulator. When use_acc is set, that accumulator replaces operand a.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   a, b [N-1:0]        operands (unsigned)
//   operacion [3:0]     0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor,
//                       8 shl, 9 shr, 10 mov(b); 11-15 illegal
//   use_acc             substitute the accumulator for a
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   resultado [N-1:0]   registered result
//   flagsResult [3:0]   registered {N,Z,C,V}
//   out_valid/out_ready result handshake
module calculadora_secuencial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   operacion,
  input  logic         use_acc,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] resultado,
  output logic [3:0]   flagsResult,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DIVIDE, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_MOV = 4'd10
  } op_t;

  state_t          state;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [3:0]      opc;
  logic [N-1:0]    acc;
  logic [N-1:0]    div_rem;
  logic [N-1:0]    div_quo;
  logic [CW-1:0]   div_cnt;

  logic [N-1:0]    ex_res;
  logic            ex_c;
  logic            ex_v;
  logic [3:0]      ex_flags;
  logic [N:0]      ex_wide;
  logic [2*N-1:0]  ex_prod;

  logic [N:0]      div_trial;
  logic [N-1:0]    div_res;
  logic [3:0]      div_flags;

  logic [N-1:0]    sel_a;
  logic            is_divmod;

  assign sel_a     = use_acc ? acc : a;
  assign is_divmod = (operacion == OP_DIV) || (operacion == OP_MOD);

  // Single-cycle datapath. DIV/MOD only reach this when the divisor is zero.
  always_comb begin
    ex_res  = '0;
    ex_c    = 1'b0;
    ex_v    = 1'b0;
    ex_wide = '0;
    ex_prod = '0;
    case (opc)
      OP_ADD: begin
        ex_wide = {1'b0, op_a} + {1'b0, op_b};
        ex_res  = ex_wide[N-1:0];
        ex_c    = ex_wide[N];
        ex_v    = (op_a[N-1] == op_b[N-1]) && (ex_res[N-1] != op_a[N-1]);
      end
      OP_SUB: begin
        ex_res = op_a - op_b;
        ex_c   = (op_a >= op_b);
        ex_v   = (op_a[N-1] != op_b[N-1]) && (ex_res[N-1] != op_a[N-1]);
      end
      OP_MUL: begin
        ex_prod = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
        ex_res  = ex_prod[N-1:0];
        ex_c    = |ex_prod[2*N-1:N];
        ex_v    = ex_c;
      end
      OP_DIV: begin
        ex_res = '1;
        ex_v   = 1'b1;
      end
      OP_MOD: begin
        ex_res = op_a;
        ex_v   = 1'b1;
      end
      OP_AND: ex_res = op_a & op_b;
      OP_OR:  ex_res = op_a | op_b;
      OP_XOR: ex_res = op_a ^ op_b;
      OP_MOV: ex_res = op_b;
      OP_SHL: begin
        // The extra top bit catches the last bit shifted out (0 for amount 0).
        ex_wide = {1'b0, op_a} << op_b[SW-1:0];
        ex_res  = ex_wide[N-1:0];
        ex_c    = ex_wide[N];
      end
      OP_SHR: begin
        ex_wide = {op_a, 1'b0} >> op_b[SW-1:0];
        ex_res  = ex_wide[N:1];
        ex_c    = ex_wide[0];
      end
      default: ex_res = '0;
    endcase
    ex_flags = {ex_res[N-1], (ex_res == '0), ex_c, ex_v};
  end

  // Restoring step: a clear MSB means the shifted partial remainder is >= divisor.
  assign div_trial = {div_rem, div_quo[N-1]} - {1'b0, op_b};
  assign div_res   = (opc == OP_DIV) ? div_quo : div_rem;
  assign div_flags = {div_res[N-1], (div_res == '0), 1'b0, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      resultado   <= '0;
      flagsResult <= '0;
      acc         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      opc         <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= sel_a;
            op_b     <= b;
            opc      <= operacion;
            in_ready <= 1'b0;
            if (is_divmod && (b != '0)) begin
              div_rem <= '0;
              div_quo <= sel_a;
              div_cnt <= '0;
              state   <= DIVIDE;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          resultado   <= ex_res;
          flagsResult <= ex_flags;
          state       <= DONE;
        end
        DIVIDE: begin
          // N iteration cycles followed by one cycle to publish the result,
          // which keeps divide latency at N cycles beyond the EXEC path.
          if (div_cnt == CW'(N)) begin
            resultado   <= div_res;
            flagsResult <= div_flags;
            state       <= DONE;
          end else begin
            if (!div_trial[N]) begin
              div_rem <= div_trial[N-1:0];
              div_quo <= {div_quo[N-2:0], 1'b1};
            end else begin
              div_rem <= {div_rem[N-2:0], div_quo[N-1]};
              div_quo <= {div_quo[N-2:0], 1'b0};
            end
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= resultado;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
